// File: rtl/programmable_seq_generator.sv
// Programmable serial pattern generator: sends a captured pattern MSB first,
// a fixed number of times or continuously. Define PSG_GAP_EN for one idle GAP cycle between repetitions.
module programmable_seq_generator #(
    parameter int PAT_W = 5,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pat,
    input  logic [REP_W-1:0] load_reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

`ifdef PSG_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_e;
`endif

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               fs_q, fs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   idx_dec;
    logic               last_rep;

    assign idx_dec  = idx_q - IDX_W'(1);
    // reps_q holds the repetitions still owed including the current one; 0 means run forever
    assign last_rep = (reps_q == REP_W'(1));

    assign load_ready  = (state_q == S_IDLE) && !abort;
    assign dout        = dout_q;
    assign dout_valid  = vld_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_valid && load_ready) begin
                    pat_d   = load_pat;
                    reps_d  = load_reps;
                    idx_d   = IDX_MSB;
                    state_d = S_SEND;
                    dout_d  = load_pat[PAT_W-1];
                    vld_d   = 1'b1;
                    fs_d    = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q != '0) begin
                    idx_d  = idx_dec;
                    dout_d = pat_q[idx_dec];
                    vld_d  = 1'b1;
                    done_d = (idx_q == IDX_W'(1)) && last_rep;
                end else if (last_rep) begin
                    state_d = S_IDLE;
                end else begin
                    // Saturate at 0 so continuous mode never starts counting
                    if (reps_q != '0)
                        reps_d = reps_q - REP_W'(1);
`ifdef PSG_GAP_EN
                    state_d = S_GAP;
`else
                    idx_d  = IDX_MSB;
                    dout_d = pat_q[PAT_W-1];
                    vld_d  = 1'b1;
                    fs_d   = 1'b1;
`endif
                end
            end
`ifdef PSG_GAP_EN
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND;
                    idx_d   = IDX_MSB;
                    dout_d  = pat_q[PAT_W-1];
                    vld_d   = 1'b1;
                    fs_d    = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
